// File: rtl/comp_pkg.sv
// Shared types and result encodings for the bit-serial magnitude comparator.
package comp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [2:0] RES_LG = 3'b100;
  localparam logic [2:0] RES_EQ = 3'b010;
  localparam logic [2:0] RES_RG = 3'b001;

  localparam logic [2:0] FLAGS_INIT = RES_EQ;

endpackage

// File: rtl/comp_bit_cell.sv
// One-bit compare cell; SERIAL_COMP_SIGNED_EN swaps the MSB step for two's complement operands.
module comp_bit_cell
  import comp_pkg::*;
(
  input  logic       x,
  input  logic       y,
  input  logic [2:0] flags_in,
  input  logic       msb_sel,
  output logic [2:0] flags_out
);

`ifdef SERIAL_COMP_SIGNED_EN
  localparam logic SIGNED_EN = 1'b1;
`else
  localparam logic SIGNED_EN = 1'b0;
`endif

  logic swap;
  assign swap = msb_sel & SIGNED_EN;

  always_comb begin
    flags_out = RES_RG;
    if (x & ~y) begin
      flags_out = swap ? RES_RG : RES_LG;
    end else if (~x & y) begin
      flags_out = swap ? RES_LG : RES_RG;
    end else if (flags_in[2]) begin
      flags_out = RES_LG;
    end else if (flags_in[1]) begin
      flags_out = RES_EQ;
    end else begin
      flags_out = RES_RG;
    end
  end

endmodule

// File: rtl/serial_comp_ctrl.sv
// Bit-serial magnitude comparator sequencer, LSB-first over WIDTH cycles.
// Optional build macro: SERIAL_COMP_SIGNED_EN (two's complement operands).
module serial_comp_ctrl
  import comp_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic             LG_OUT,
  output logic             EQ_OUT,
  output logic             RG_OUT,
  output logic             BUSY
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state, state_next;

  logic [WIDTH-1:0] x_sh, y_sh;
  logic [CW-1:0]    cnt;
  logic [2:0]       flags;
  logic [2:0]       cell_out;
  logic [2:0]       result;
  logic             last_bit;

  assign last_bit = (cnt == LAST);

  comp_bit_cell u_cell (
    .x         (x_sh[0]),
    .y         (y_sh[0]),
    .flags_in  (flags),
    .msb_sel   (last_bit),
    .flags_out (cell_out)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (IN_VALID) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    if (OUT_READY) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath follows the registered state so operands are only latched in IDLE
  always_ff @(posedge CLK) begin
    if (RST) begin
      x_sh   <= '0;
      y_sh   <= '0;
      cnt    <= '0;
      flags  <= '0;
      result <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (IN_VALID) begin
            x_sh  <= X;
            y_sh  <= Y;
            flags <= FLAGS_INIT;
            cnt   <= '0;
          end
        end
        RUN: begin
          x_sh  <= x_sh >> 1;
          y_sh  <= y_sh >> 1;
          flags <= cell_out;
          cnt   <= cnt + CW'(1);
          if (last_bit) begin
            result <= cell_out;
          end
        end
        default: ;
      endcase
    end
  end

  assign IN_READY  = (state == IDLE);
  assign OUT_VALID = (state == DONE);
  assign BUSY      = (state != IDLE);
  assign LG_OUT    = result[2];
  assign EQ_OUT    = result[1];
  assign RG_OUT    = result[0];

endmodule

// File: doc/serial_comp_ctrl.md
Name: serial_comp_ctrl

Overview:
Bit-serial magnitude comparator sequencer. Accepts one pair of WIDTH-bit operands through a valid/ready handshake. Steps a single 1-bit compare cell LSB-first over WIDTH cycles, carrying the LG/EQ/RG flags between cycles in registers. Returns a one-hot result through a valid/ready handshake. Replaces the WIDTH-instance ripple chain where area matters more than latency.

Parameters:
WIDTH, 4, operand width in bits; legal range 2..32.

Ports:
CLK  input  1  clock; all state updates on rising edge
RST  input  1  synchronous active-high reset
IN_VALID  input  1  operand pair valid
IN_READY  output  1  block can accept operands
X  input  WIDTH  operand X
Y  input  WIDTH  operand Y
OUT_VALID  output  1  result valid
OUT_READY  input  1  consumer accepts result
LG_OUT  output  1  X > Y
EQ_OUT  output  1  X == Y
RG_OUT  output  1  X < Y
BUSY  output  1  high in RUN or DONE

Behaviour:
- One clock (CLK). RST is synchronous and active-high. All outputs are registered or decoded from state.
- Reset values:
  - state=IDLE, IN_READY=1, OUT_VALID=0, BUSY=0.
  - LG_OUT=EQ_OUT=RG_OUT=0.
  - Shift registers and counter = 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - IN_READY=1.
  - On IN_VALID&IN_READY: latch X and Y into shift registers, init flags {LG,EQ,RG}=3'b010, counter=0, go to RUN.
  - IN_VALID low: stay in IDLE.
- RUN:
  - IN_READY=0; IN_VALID ignored.
  - Each cycle apply the cell rule to the current LSBs (x,y) and flags:
    - x>y → 100.
    - x<y → 001.
    - x==y → keep the incoming flags (LG if LG_in, else EQ if EQ_in, else RG).
  - Shift both registers right by 1, counter+1.
  - On the cycle where counter==WIDTH-1: load the final flags into LG_OUT/EQ_OUT/RG_OUT and go to DONE.
- DONE:
  - OUT_VALID=1; result outputs stable.
  - On OUT_READY: go to IDLE and clear OUT_VALID.
  - Result outputs hold their last value after leaving DONE; they are meaningful only while OUT_VALID=1.
- Latency: input handshake in cycle t → OUT_VALID first high in cycle t+WIDTH+1. Throughput: one compare per WIDTH+2 cycles at best. No overlap between operand pairs.
- Invariants:
  - Exactly one of LG_OUT/EQ_OUT/RG_OUT is high whenever OUT_VALID=1.
  - IN_READY and OUT_VALID are never both high.
- Counter width: $clog2(WIDTH); wrap is never reached because the transition occurs at WIDTH-1.
- Boundary conditions:
  - RST in any state, including mid-RUN: operation abandoned, all reset values restored next cycle, no OUT_VALID pulse.
  - IN_VALID held high through DONE: not accepted until back in IDLE (one cycle after OUT_READY).
  - OUT_READY high on DONE entry: OUT_VALID is high for exactly one cycle.
  - OUT_READY high outside DONE: ignored.
  - X and Y change after the handshake: no effect; operands were latched.

Optional Feature:
- SERIAL_COMP_SIGNED_EN.
- Defined: operands are two's complement. On the MSB step (counter==WIDTH-1) the cell treats x>y as 001 and x<y as 100; the equal case is unchanged.
- Undefined: unsigned compare at every bit.
- Latency and handshake are identical in both builds.

Decomposition:
- Package comp_pkg:
  - state enum (IDLE, RUN, DONE).
  - result encodings: RES_LG=3'b100, RES_EQ=3'b010, RES_RG=3'b001.
  - flag-initialisation constant RES_EQ.
- Sub-module comp_bit_cell: purely combinational. Ports x, y, flags_in[2:0], msb_sel; output flags_out[2:0]. msb_sel is used only under SERIAL_COMP_SIGNED_EN.
- The controller holds the FSM, counter, shift registers and output registers.

Test Plan:
- WIDTH=4, X=9, Y=3, OUT_READY=1: handshake at t → OUT_VALID=1 at t+5 with LG/EQ/RG=100, one-cycle pulse, IN_READY=1 at t+6.
- X=7, Y=7 → EQ_OUT=1 only. X=2, Y=12 → RG_OUT=1 only. X=0, Y=15 → RG. X=15, Y=0 → LG.
- Backpressure: X=5, Y=6, OUT_READY low for 3 cycles after OUT_VALID rises. During that time OUT_VALID and RG_OUT=1 are held stable, IN_READY=0, and a new IN_VALID is not accepted. OUT_READY=1 → IDLE next cycle.
- RST asserted in the 2nd RUN cycle → next cycle IDLE, IN_READY=1, outputs 000, no OUT_VALID. A fresh compare of X=3, Y=3 then returns EQ.
- X=4'b1001, Y=4'b0011: without macro → LG (9>3); with SERIAL_COMP_SIGNED_EN → RG (-7<3). X=4'b1000, Y=4'b1111 signed → RG (-8<-1).
- Random back-to-back pairs over 1000 compares, each checked against a reference compare: result matches, the one-hot invariant holds, and the WIDTH+1 latency holds.
